lcu_seq_adder_ctrl: RTL and testbench

Multi-cycle sequencer that computes a WIDTH-bit add or subtract by time-multiplexing a single `four_bit_LCU_adder` slice over WIDTH/4 clock cycles. It runs the least-significant nibble first and carries between nibbles through a registered carry. It sits between a requesting unit that uses a start/ready/done handshake and the existing 4-bit carry-lookahead adder datapath. This trades latency for area when a wide adder is not justified.

---
 rtl/lcu_seq_adder_ctrl_pkg.sv | 17 +
 rtl/lcu_seq_adder_ctrl_if.sv | 26 ++
 rtl/lcu_seq_adder_ctrl_lcu.sv | 29 ++
 rtl/lcu_seq_adder_ctrl.sv | 98 +++++++++
 tb/tb_lcu_seq_adder_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/lcu_seq_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
package lcu_seq_adder_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam int unsigned DEF_WIDTH = 16;
   localparam int unsigned N         = DEF_WIDTH / 4;

   function automatic int unsigned nibble_count(input int unsigned width);
      return width / 4;
   endfunction

endpackage

// File: rtl/lcu_seq_adder_ctrl_if.sv
// Request/result bundle between a requesting unit (master) and the sequencer (slave).
interface lcu_seq_adder_ctrl_if #(
   parameter int unsigned WIDTH = 16
);
   logic             start;
   logic             sub;
   logic             cin;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output start, sub, cin, a, b,
      input  ready, busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, sub, cin, a, b,
      output ready, busy, done, sum, cout, ovf
   );
endinterface

// File: rtl/lcu_seq_adder_ctrl_lcu.sv
// Existing 4-bit carry-lookahead adder slice with group propagate/generate.
module four_bit_LCU_adder (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] sum,
   output logic       co,
   output logic       po,
   output logic       go
);
   logic [3:0] p;
   logic [3:0] g;
   logic [4:0] c;

   always_comb begin
      p    = a ^ b;
      g    = a & b;
      c[0] = ci;
      c[1] = g[0] | (p[0] & c[0]);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c[0]);
      sum  = p ^ c[3:0];
      co   = c[4];
      po   = &p;
      go   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   end
endmodule

// File: rtl/lcu_seq_adder_ctrl.sv
// Wide add/subtract computed LSB nibble first through one 4-bit lookahead slice.
module lcu_seq_adder_ctrl
   import lcu_seq_adder_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   lcu_seq_adder_ctrl_if.slave bus
);
   localparam int unsigned     NIB      = nibble_count(WIDTH);
   localparam int unsigned     IDX_W    = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] sum_reg;
   logic [IDX_W-1:0] idx;
   logic             carry;
   logic             cout_reg;
   logic             ovf_reg;
   logic             accept;
   logic             last;
   logic [3:0]       nib_a;
   logic [3:0]       nib_b;
   logic [3:0]       nib_s;
   logic             nib_co;

   assign accept = (state == IDLE) && bus.start;
   assign last   = (state == RUN) && (idx == LAST_IDX);
   assign nib_a  = a_reg[4*idx +: 4];
   assign nib_b  = b_reg[4*idx +: 4];

   four_bit_LCU_adder u_slice (
      .a   (nib_a),
      .b   (nib_b),
      .ci  (carry),
      .sum (nib_s),
      .co  (nib_co),
      .po  (),
      .go  ()
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = RUN;
         RUN:     if (last)      state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.ready = (state == IDLE);
      bus.busy  = (state == RUN);
      bus.done  = (state == DONE);
   end

   // b is stored already inverted for subtract so the slice only ever adds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg    <= '0;
         b_reg    <= '0;
         sum_reg  <= '0;
         idx      <= '0;
         carry    <= 1'b0;
         cout_reg <= 1'b0;
         ovf_reg  <= 1'b0;
      end else if (accept) begin
         a_reg <= bus.a;
         b_reg <= bus.sub ? ~bus.b : bus.b;
         carry <= bus.sub ? 1'b1 : bus.cin;
         idx   <= '0;
      end else if (state == RUN) begin
         sum_reg[4*idx +: 4] <= nib_s;
         carry               <= nib_co;
         if (last) begin
            idx      <= '0;
            cout_reg <= nib_co;
            ovf_reg  <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ nib_s[3] ^ nib_co;
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end

   assign bus.sum  = sum_reg;
   assign bus.cout = cout_reg;
   assign bus.ovf  = ovf_reg;
endmodule

// File: tb/tb_lcu_seq_adder_ctrl.sv
// Randomized and directed bench for lcu_seq_adder_ctrl against a plain-arithmetic model.
module tb_lcu_seq_adder_ctrl;
   localparam int W = 16;
   localparam int N = W / 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   lcu_seq_adder_ctrl_if #(.WIDTH(W)) bus ();

   lcu_seq_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Returns {ovf, cout, sum} from ordinary integer arithmetic.
   function automatic logic [17:0] ref_op(input logic [15:0] a, input logic [15:0] b,
                                          input logic s, input logic c);
      logic [15:0] bp;
      logic [16:0] full;
      logic        ov;
      bp   = s ? ~b : b;
      full = {1'b0, a} + {1'b0, bp} + {16'd0, (s ? 1'b1 : c)};
      ov   = (a[15] == bp[15]) && (full[15] != a[15]);
      return {ov, full[16], full[15:0]};
   endfunction

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL wait_ready timeout ready=%b required=1", bus.ready);
      end
   endtask

   // Entered and left at a negedge with the sequencer idle.
   task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic c);
      logic [17:0] exp;
      bit          ok;
      exp = ref_op(a, b, s, c);
      wait_ready(ok);
      if (!ok) return;
      bus.a = a; bus.b = b; bus.sub = s; bus.cin = c; bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.a = 16'($urandom); bus.b = 16'($urandom);
      bus.sub = 1'($urandom); bus.cin = 1'($urandom);
      for (int k = 1; k <= N + 1; k++) begin
         @(negedge clk);
         checks++;
         if (bus.ready !== 1'b0 || bus.busy !== 1'(k <= N) || bus.done !== 1'(k == N + 1)) begin
            errors++;
            $display("FAIL %s handshake cycle=%0d ready/busy/done=%b%b%b required=0%b%b",
                     name, k, bus.ready, bus.busy, bus.done, 1'(k <= N), 1'(k == N + 1));
         end
      end
      checks++;
      if ({bus.ovf, bus.cout, bus.sum} !== exp) begin
         errors++;
         $display("FAIL %s result ovf=%b cout=%b sum=%h required ovf=%b cout=%b sum=%h",
                  name, bus.ovf, bus.cout, bus.sum, exp[17], exp[16], exp[15:0]);
      end
      @(negedge clk);
      checks++;
      if (bus.ready !== 1'b1 || bus.done !== 1'b0 || {bus.ovf, bus.cout, bus.sum} !== exp) begin
         errors++;
         $display("FAIL %s hold ready=%b done=%b sum=%h required ready=1 done=0 sum=%h",
                  name, bus.ready, bus.done, bus.sum, exp[15:0]);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.start = 1'b0; bus.sub = 1'b0; bus.cin = 1'b0; bus.a = '0; bus.b = '0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
          bus.sum !== 16'h0000 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset_state ready=%b busy=%b done=%b sum=%h cout=%b ovf=%b required 1 0 0 0000 0 0",
                  bus.ready, bus.busy, bus.done, bus.sum, bus.cout, bus.ovf);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      run_op("add_basic",    16'h1234, 16'h4321, 1'b0, 1'b0);
      run_op("ripple_b1",    16'hFFFF, 16'h0001, 1'b0, 1'b0);
      run_op("ripple_cin",   16'hFFFF, 16'h0000, 1'b0, 1'b1);
      run_op("ovf_add",      16'h7FFF, 16'h0001, 1'b0, 1'b0);
      run_op("ovf_sub",      16'h8000, 16'h0001, 1'b1, 1'b0);
      run_op("sub_borrow",   16'h0005, 16'h0007, 1'b1, 1'b1);
      run_op("sub_equal",    16'hA5A5, 16'hA5A5, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 25; i++)
         run_op("random", 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
   endtask

   // start held high the whole time: only edges E0 and E(N+2) may accept.
   task automatic test_back_to_back();
      logic [17:0] exp1;
      logic [17:0] exp2;
      logic [15:0] a2;
      logic [15:0] b2;
      bit          ok;
      a2   = 16'($urandom);
      b2   = 16'($urandom);
      exp1 = ref_op(16'h1357, 16'h2468, 1'b0, 1'b1);
      exp2 = ref_op(a2, b2, 1'b1, 1'b0);
      wait_ready(ok);
      if (!ok) return;
      bus.a = 16'h1357; bus.b = 16'h2468; bus.sub = 1'b0; bus.cin = 1'b1; bus.start = 1'b1;
      for (int op = 0; op < 2; op++) begin
         @(posedge clk);
         #1;
         bus.a = 16'($urandom); bus.b = 16'($urandom);
         bus.sub = 1'($urandom); bus.cin = 1'($urandom);
         for (int k = 1; k <= N + 1; k++) begin
            @(negedge clk);
            checks++;
            if (bus.ready !== 1'b0 || bus.done !== 1'(k == N + 1)) begin
               errors++;
               $display("FAIL b2b op=%0d cycle=%0d ready=%b done=%b required ready=0 done=%b",
                        op, k, bus.ready, bus.done, 1'(k == N + 1));
            end
            bus.a = 16'($urandom); bus.b = 16'($urandom);
         end
         checks++;
         if ({bus.ovf, bus.cout, bus.sum} !== (op == 0 ? exp1 : exp2)) begin
            errors++;
            $display("FAIL b2b_result op=%0d got=%h required=%h", op,
                     {bus.ovf, bus.cout, bus.sum}, (op == 0 ? exp1 : exp2));
         end
         @(negedge clk);
         checks++;
         if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ready op=%0d ready=%b done=%b required ready=1 done=0",
                     op, bus.ready, bus.done);
         end
         if (op == 0) begin
            bus.a = a2; bus.b = b2; bus.sub = 1'b1; bus.cin = 1'b0;
         end else begin
            bus.start = 1'b0;
         end
      end
      @(negedge clk);
      checks++;
      if (bus.ready !== 1'b1 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle ready=%b busy=%b required ready=1 busy=0", bus.ready, bus.busy);
      end
   endtask

   task automatic test_reset_mid_op();
      bit ok;
      run_op("pre_reset", 16'h1111, 16'h2222, 1'b0, 1'b0);
      wait_ready(ok);
      if (!ok) return;
      bus.a = 16'h4444; bus.b = 16'h3333; bus.sub = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.ready !== 1'b1 || bus.done !== 1'b0 ||
          bus.sum !== 16'h0000 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_op busy=%b ready=%b done=%b sum=%h cout=%b ovf=%b required 0 1 0 0000 0 0",
                  bus.busy, bus.ready, bus.done, bus.sum, bus.cout, bus.ovf);
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold done=%b busy=%b required 0 0", bus.done, bus.busy);
      end
      rst_n = 1'b1;
      @(negedge clk);
      run_op("post_reset", 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_mid_op();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
